// File: rtl/router_out_arbiter_if.sv
// Handshake bundle between one router output port arbiter and its input buffers / downstream buffer.
// master: buffer/downstream side; slave: arbiter side.
interface router_out_arbiter_if #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned FLIT_W  = 8
);
    localparam int unsigned OwnW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*FLIT_W-1:0] flit_in;
    logic                      out_ready;
    logic [NUM_REQ-1:0]        gnt;
    logic [FLIT_W-1:0]         flit_out;
    logic                      flit_out_valid;
    logic                      busy;
    logic [OwnW-1:0]           owner;
    logic                      stray_err;
    logic                      timeout_err;

    modport master (
        output req, flit_in, out_ready,
        input  gnt, flit_out, flit_out_valid, busy, owner, stray_err, timeout_err
    );

    modport slave (
        input  req, flit_in, out_ready,
        output gnt, flit_out, flit_out_valid, busy, owner, stray_err, timeout_err
    );
endinterface

// File: rtl/router_out_arbiter.sv
// Packet-granular round-robin arbiter and output register for one mesh router output port.
// Optional owner-stall abort is compiled in with ARB_TIMEOUT_EN.
module router_out_arbiter #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned FLIT_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input logic                 clk,
    input logic                 rst,
    router_out_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e              state_q;
    logic [IdxW-1:0]     ptr_q, owner_q, win_idx, sel_idx;
    logic                win_found, xfer, sel_tail;
    logic [NUM_REQ-1:0]  head, tail, eligible, stray, gnt_c;
    logic [FLIT_W-1:0]   sel_flit, flit_out_q;
    logic                valid_q, stray_q;

    function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] i);
        return (int'(i) == int'(NUM_REQ) - 1) ? '0 : IdxW'(int'(i) + 1);
    endfunction

    always_comb begin
        int idx;
        idx = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            head[i] = bus.flit_in[i*FLIT_W + FLIT_W - 1];
            tail[i] = bus.flit_in[i*FLIT_W + FLIT_W - 2];
        end
        eligible = bus.req & head;
        stray    = bus.req & ~head;

        // First eligible input at or above ptr, wrapping to 0.
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = IdxW'(idx);
            end
        end

        if (state_q == StIdle) begin
            sel_idx = win_idx;
            xfer    = win_found & bus.out_ready;
        end else begin
            sel_idx = owner_q;
            xfer    = bus.req[owner_q] & bus.out_ready;
        end

        gnt_c          = '0;
        gnt_c[sel_idx] = xfer;
        sel_flit       = bus.flit_in[sel_idx*FLIT_W +: FLIT_W];
        sel_tail       = tail[sel_idx];
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] stall_q;
    logic            timeout_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            owner_q    <= '0;
            flit_out_q <= '0;
            valid_q    <= 1'b0;
            stray_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            stall_q    <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            valid_q <= xfer;
            stray_q <= (state_q == StIdle) && (|stray);
            if (xfer) flit_out_q <= sel_flit;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (xfer) begin
                        if (sel_tail) begin
                            ptr_q <= inc_idx(sel_idx);
                        end else begin
                            state_q <= StLocked;
                            owner_q <= sel_idx;
                        end
                    end
                end
                StLocked: begin
                    if (xfer && sel_tail) begin
                        state_q <= StIdle;
                        ptr_q   <= inc_idx(owner_q);
                    end
`ifdef ARB_TIMEOUT_EN
                    // Only an absent owner counts; downstream backpressure does not.
                    if (xfer) begin
                        stall_q <= '0;
                    end else if (!bus.req[owner_q]) begin
                        if (stall_q == CntW'(TIMEOUT - 1)) begin
                            state_q   <= StIdle;
                            ptr_q     <= inc_idx(owner_q);
                            timeout_q <= 1'b1;
                            stall_q   <= '0;
                        end else begin
                            stall_q <= stall_q + 1'b1;
                        end
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.gnt            = rst ? gnt_c : '0;
    assign bus.flit_out       = flit_out_q;
    assign bus.flit_out_valid = valid_q;
    assign bus.busy           = (state_q == StLocked);
    assign bus.owner          = owner_q;
    assign bus.stray_err      = stray_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout_err    = timeout_q;
`else
    assign bus.timeout_err    = 1'b0;
`endif
endmodule

// File: tb/tb_router_out_arbiter.sv
// Scoreboard bench for router_out_arbiter: directed vectors push expected flits, a negedge
// monitor pops them whenever flit_out_valid is seen.
module tb_router_out_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    router_out_arbiter_if #(.NUM_REQ(5), .FLIT_W(8)) bus ();

    router_out_arbiter #(.NUM_REQ(5), .FLIT_W(8), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int to_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle: apply inputs, check the combinational grant, record the expected flit.
    task automatic drive(input string name, input logic [4:0] r, input logic [39:0] f,
                         input logic rdy, input logic [4:0] eg);
        bus.req = r;
        bus.flit_in = f;
        bus.out_ready = rdy;
        #1;
        chk({name, " gnt"}, 32'(bus.gnt), 32'(eg));
        for (int i = 0; i < 5; i++) if (eg[i]) exp_q.push_back(f[i*8 +: 8]);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.flit_out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_flit: got %0h, expected no flit", bus.flit_out);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("flit_out", 32'(bus.flit_out), 32'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rr_gnt [6];
        rr_gnt = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

        rst = 1'b1;
        bus.req = 5'b00001;
        bus.flit_in = {32'h0, 8'hC5};
        bus.out_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset gnt", 32'(bus.gnt), 0);
        chk("reset valid", 32'(bus.flit_out_valid), 0);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset flit_out", 32'(bus.flit_out), 0);
        bus.req = '0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Round robin from ptr=0 over single-flit packets.
        for (int c = 0; c < 6; c++)
            drive("round_robin", 5'b11111, {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0}, 1'b1, rr_gnt[c]);

        // Single-flit on input 0 (ptr=1 here), then ptr must point past it.
        drive("single", 5'b00001, {32'h0, 8'hC5}, 1'b1, 5'b00001);
        chk("single valid", 32'(bus.flit_out_valid), 1);
        chk("single flit_out", 32'(bus.flit_out), 32'hC5);
        drive("ptr_after_single", 5'b00011, {24'h0, 8'hC1, 8'hC5}, 1'b1, 5'b00010);

        // Lock by input 2 (ptr=2) while input 0 waits.
        drive("lock_head", 5'b00101, {16'h0, 8'h82, 8'h00, 8'hC0}, 1'b1, 5'b00100);
        chk("lock busy1", 32'(bus.busy), 1);
        chk("lock owner", 32'(bus.owner), 2);
        drive("lock_body", 5'b00101, {16'h0, 8'h05, 8'h00, 8'hC0}, 1'b1, 5'b00100);
        chk("lock busy2", 32'(bus.busy), 1);
        drive("lock_tail", 5'b00101, {16'h0, 8'h41, 8'h00, 8'hC0}, 1'b1, 5'b00100);
        chk("lock busy_after_tail", 32'(bus.busy), 0);
        drive("lock_next", 5'b00001, {32'h0, 8'hC0}, 1'b1, 5'b00001);

        // Backpressure mid-packet on input 3 with input 1 competing.
        drive("bp_head", 5'b01000, {8'h0, 8'h88, 24'h0}, 1'b1, 5'b01000);
        drive("bp_body", 5'b01000, {8'h0, 8'h11, 24'h0}, 1'b1, 5'b01000);
        for (int s = 0; s < 3; s++) begin
            drive("bp_stall", 5'b01010, {8'h0, 8'h22, 8'h0, 8'hC1, 8'h0}, 1'b0, 5'b00000);
            chk("bp_stall valid", 32'(bus.flit_out_valid), 0);
            chk("bp_stall busy", 32'(bus.busy), 1);
        end
        drive("bp_resume", 5'b01010, {8'h0, 8'h22, 8'h0, 8'hC1, 8'h0}, 1'b1, 5'b01000);
        drive("bp_tail", 5'b01010, {8'h0, 8'h53, 8'h0, 8'hC1, 8'h0}, 1'b1, 5'b01000);
        drive("bp_next", 5'b00010, {24'h0, 8'hC1, 8'h0}, 1'b1, 5'b00010);

        // Stray body flit while idle.
        drive("stray", 5'b01000, {8'h0, 8'h05, 24'h0}, 1'b1, 5'b00000);
        chk("stray_err set", 32'(bus.stray_err), 1);
        drive("stray_clear", 5'b00000, 40'h0, 1'b1, 5'b00000);
        chk("stray_err clear", 32'(bus.stray_err), 0);

        // Owner 1 vanishes after its head.
        drive("owner1_head", 5'b00010, {24'h0, 8'h81, 8'h0}, 1'b1, 5'b00010);
        chk("owner1 busy", 32'(bus.busy), 1);
        to_cnt = 0;
        for (int s = 0; s < 6; s++) begin
            drive("owner_stall", 5'b00000, 40'h0, 1'b1, 5'b00000);
            if (bus.timeout_err === 1'b1) to_cnt++;
        end
`ifdef ARB_TIMEOUT_EN
        chk("timeout busy dropped", 32'(bus.busy), 0);
        chk("timeout pulses", 32'(to_cnt), 1);
        drive("timeout_ptr", 5'b00110, {16'h0, 8'hC2, 8'hC1, 8'h0}, 1'b1, 5'b00100);
`else
        chk("no_timeout busy held", 32'(bus.busy), 1);
        chk("no_timeout pulses", 32'(to_cnt), 0);
`endif
        drive("relock", 5'b00010, {24'h0, 8'h81, 8'h0}, 1'b1, 5'b00010);
        drive("drain", 5'b00000, 40'h0, 1'b1, 5'b00000);

        // Asynchronous reset in the middle of a lock.
        bus.req = 5'b00010;
        bus.flit_in = {24'h0, 8'h03, 8'h0};
        bus.out_ready = 1'b1;
        #1;
        chk("pre_reset gnt", 32'(bus.gnt), 32'b00010);
        rst = 1'b0;
        #1;
        chk("midlock reset gnt", 32'(bus.gnt), 0);
        chk("midlock reset busy", 32'(bus.busy), 0);
        chk("midlock reset owner", 32'(bus.owner), 0);
        chk("midlock reset flit_out", 32'(bus.flit_out), 0);
        chk("midlock reset valid", 32'(bus.flit_out_valid), 0);
        bus.req = '0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        drive("ptr_after_reset", 5'b11111, {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0}, 1'b1, 5'b00001);
        drive("idle1", 5'b00000, 40'h0, 1'b1, 5'b00000);
        drive("idle2", 5'b00000, 40'h0, 1'b1, 5'b00000);
        chk("scoreboard empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Per-output-port arbiter and crossbar stage for a mesh router. It shares one router output port (N/E/S/W/Local) among the input buffers of the same router. Arbitration is round-robin at packet granularity: a granted input holds the port from head flit to tail flit. The block pops the granted input buffer through a one-hot read strobe and registers the selected flit toward the downstream buffer's write side.

## Interface
- NUM_REQ, 5, number of competing input buffers (N, E, S, W, L).
- FLIT_W, 8, flit width. Bit [FLIT_W-1] is the head flag and bit [FLIT_W-2] is the tail flag.
- TIMEOUT, 16, owner-stall limit in cycles (used only with ARB_TIMEOUT_EN).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  input i's buffer is non-empty and its front flit targets this port.
- flit_in  in  NUM_REQ*FLIT_W  front flit of each buffer; input i occupies slice [i*FLIT_W +: FLIT_W].
- out_ready  in  1  downstream buffer can accept a flit this cycle (not full).
- gnt  out  NUM_REQ  one-hot combinational pop strobe (Read) to the input that transfers this cycle.
- flit_out  out  FLIT_W  registered selected flit.
- flit_out_valid  out  1  registered write strobe (Write) to the downstream buffer.
- busy  out  1  a packet lock is held.
- owner  out  $clog2(NUM_REQ)  index of the lock holder; valid while busy.
- stray_err  out  1  one-cycle pulse when a non-head flit is presented while IDLE.
- timeout_err  out  1  one-cycle pulse on lock abort; tied 0 when ARB_TIMEOUT_EN is undefined.

## Operation
- State machine has two states, IDLE and LOCKED. Round-robin pointer `ptr` is in 0..NUM_REQ-1.
- IDLE, eligibility: input i is eligible when req[i]=1 and its flit has the head bit set.
- IDLE, stray flits: if req[i]=1 with the head bit clear, input i is masked and stray_err pulses. The flit is not popped.
- IDLE, winner selection: the winner is the first eligible input searching from ptr upward, wrapping to 0.
- IDLE, transfer: the transfer happens only if out_ready=1. Then gnt[winner]=1.
  - If the head flit also has the tail bit set (single-flit packet): stay IDLE, ptr←winner+1 mod NUM_REQ.
  - Otherwise: go to LOCKED, owner←winner.
- IDLE, no transfer: if out_ready=0, there is no grant and ptr does not change.
- LOCKED, transfer: the transfer happens when req[owner]=1 and out_ready=1, giving gnt[owner]=1. Other inputs are never granted while LOCKED.
- LOCKED, tail: when the transferred flit has the tail bit set, go to IDLE and set ptr←owner+1 mod NUM_REQ.
- LOCKED, other flits: head bits on body flits inside a lock are ignored and forwarded unchanged.
- LOCKED, stall: if req[owner]=0 or out_ready=0, the block stalls with gnt=0 and the lock is held.
- Data path: flit_out loads flit_in of the granted input on each transfer, and holds its value otherwise.
- Valid: flit_out_valid is 1 in the cycle after a transfer, else 0.
- Gating: gnt is forced to 0 while rst is low.
- Reset values: state IDLE, ptr 0, owner 0, busy 0, flit_out 0, flit_out_valid 0, stray_err 0, timeout_err 0, stall counter 0.

## Timing
- gnt is combinational from req, flit_in, out_ready and state. The buffer pops at the same clock edge as the transfer.
- Latency is 1 cycle from transfer to flit_out/flit_out_valid.
- Throughput is one flit per cycle, including tail-to-head back-to-back with a different winner.
- Simultaneous events: tail transfer and new requests in the same cycle cause no extra grant. The next winner is chosen in the following cycle from the updated ptr.
- Reset mid-packet: the lock is dropped immediately. Any partial packet already downstream is not the arbiter's concern.
- Wrap-around: ptr=NUM_REQ-1 advances to 0.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive LOCKED cycles with req[owner]=0.
  - When it reaches TIMEOUT, the lock is aborted: go to IDLE, ptr←owner+1, timeout_err pulses for that cycle.
  - The counter clears on any owner transfer and on leaving LOCKED.
  - out_ready=0 stalls are not counted.
- Undefined: there is no counter, the lock is held indefinitely, and timeout_err is constant 0.

## Test plan
- Reset: assert rst=0 mid-lock. Required: all outputs 0 asynchronously; after release, state IDLE and ptr=0.
- Single-flit packet: req=5'b00001, flit0=8'hC5, out_ready=1. Required: gnt=5'b00001 that cycle; next cycle flit_out=8'hC5 and flit_out_valid=1; ptr=1.
- Round robin: req=5'b11111, each flit_i=8'hC0|i, held for 6 cycles. Required: gnt sequence 00001, 00010, 00100, 01000, 10000, 00001; flit_out C0, C1, C2, C3, C4, C0.
- Lock with competition: input 2 sends 8'h82, 8'h05, 8'h41 while input 0 holds 8'hC0 from the first cycle. Required: three consecutive gnt=5'b00100, then gnt=5'b00001; busy high for exactly the two cycles after the head.
- Backpressure: out_ready=0 for 3 cycles mid-packet. Required: gnt=0 and flit_out_valid=0 during the stall; the packet resumes with no flit lost or duplicated. Separately, a stray 8'h05 on input 3 while IDLE gives stray_err=1 and no grant.
- Timeout: ARB_TIMEOUT_EN defined, TIMEOUT=4, owner 1 drops req after its head. Required: timeout_err pulses on the 4th stall cycle, then IDLE with ptr=2. With the macro undefined, busy stays high.
